// File: rtl/dm_axil_bridge.sv
// Bridges the CPU data-memory SRAM port to an AXI4-Lite master.
// One transaction is outstanding at a time; dm_stall freezes the pipeline until the bus answers.
module dm_axil_bridge #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_ceb,
  input  logic              dm_w_en,
  input  logic [31:0]       dm_bweb,
  input  logic [13:0]       dm_addr,
  input  logic [31:0]       dm_din,
  output logic [31:0]       dm_dout,
  output logic              dm_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [2:0]        m_awprot,
  output logic [2:0]        m_arprot
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        req_strb;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [3:0]        wstrb_p1;
  logic              aw_done_p1;
  logic              w_done_p1;
  logic [31:0]       dout_p1;
  logic              err_p1;

  // A byte lane is written when any bit of its active-low mask is low.
  function automatic logic [3:0] bweb_to_strb(input logic [31:0] bweb);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      s[i] = |(~bweb[8*i +: 8]);
    end
    return s;
  endfunction

  assign req_strb = bweb_to_strb(dm_bweb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    dm_stall  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    case (state)
      IDLE: begin
        if (!dm_ceb) begin
          dm_stall = 1'b1;
          if (dm_w_en) begin
            state_nx = RD_ADDR;
          end else if (req_strb != 4'b0000) begin
            state_nx = WR_REQ;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RD_ADDR: begin
        dm_stall  = 1'b1;
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_nx = RD_DATA;
        end
      end
      RD_DATA: begin
        dm_stall = 1'b1;
        m_rready = 1'b1;
        if (m_rvalid) begin
          state_nx = DONE;
        end
      end
      WR_REQ: begin
        dm_stall  = 1'b1;
        m_awvalid = !aw_done_p1;
        m_wvalid  = !w_done_p1;
        if ((aw_done_p1 || m_awready) && (w_done_p1 || m_wready)) begin
          state_nx = WR_RESP;
        end
      end
      WR_RESP: begin
        dm_stall = 1'b1;
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        // The CPU advances on this edge; a still-low dm_ceb belongs to the old access.
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (rst) begin
      dm_stall = 1'b0;
    end
  end

  // Stage p1: request payload captured in IDLE, held until the handshakes complete
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1    <= '0;
      wdata_p1   <= '0;
      wstrb_p1   <= '0;
      aw_done_p1 <= 1'b0;
      w_done_p1  <= 1'b0;
      dout_p1    <= '0;
      err_p1     <= 1'b0;
    end else begin
      if (state == IDLE && !dm_ceb) begin
        addr_p1    <= {BASE_ADDR[ADDR_W-1:16], dm_addr, 2'b00};
        wdata_p1   <= dm_din;
        wstrb_p1   <= req_strb;
        aw_done_p1 <= 1'b0;
        w_done_p1  <= 1'b0;
      end
      if (state == WR_REQ) begin
        if (m_awvalid && m_awready) aw_done_p1 <= 1'b1;
        if (m_wvalid && m_wready)   w_done_p1  <= 1'b1;
      end
      if (state == RD_DATA && m_rvalid) begin
        dout_p1 <= m_rdata;
        if (m_rresp != 2'b00) err_p1 <= 1'b1;
      end
      if (state == WR_RESP && m_bvalid && m_bresp != 2'b00) begin
        err_p1 <= 1'b1;
      end
    end
  end

  assign m_awaddr = addr_p1;
  assign m_araddr = addr_p1;
  assign m_wdata  = wdata_p1;
  assign m_wstrb  = wstrb_p1;
  assign dm_dout  = dout_p1;
  assign bus_err  = err_p1;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

endmodule
